// File: rtl/mac_acl_drop_stage_pkg.sv
// Shared MAC-path definitions: field sizes, parser flag bit positions,
// tuser field offset helpers and the drop-stage FSM state encoding.
package nmu_mac_pkg;

    localparam int ET_SIZE     = 16;
    localparam int DA_MAC_SIZE = 48;
    localparam int SA_MAC_SIZE = 48;
    localparam int FLAGS_W     = 8;

    // Parser verdict flag bit positions inside the tuser flags byte
    localparam int FLG_NEXT_ACL = 0;
    localparam int FLG_SRC_ACL  = 1;
    localparam int FLG_DEST_ACL = 2;
    localparam int FLG_CAM_MISS = 3;

    typedef enum logic [1:0] {
        SOP  = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } acl_state_t;

    // tuser layout, LSB first: route[n_id], len[len_w], ethertype[16], flags[8]
    function automatic int tu_route_lo();
        return 0;
    endfunction

    function automatic int tu_len_lo(input int n_id);
        return n_id;
    endfunction

    function automatic int tu_et_lo(input int n_id, input int len_w);
        return n_id + len_w;
    endfunction

    function automatic int tu_flags_lo(input int n_id, input int len_w);
        return n_id + len_w + ET_SIZE;
    endfunction

    function automatic int tu_width(input int n_id, input int len_w);
        return n_id + len_w + ET_SIZE + FLAGS_W;
    endfunction

endpackage

// File: rtl/mac_acl_drop_stage_if.sv
// AXI-Stream bus with MAC parser sideband (tuser/tid/tdest).
interface mac_acl_drop_stage_if #(
    parameter int DATA_W = 64,
    parameter int USER_W = 51,
    parameter int ID_W   = 4,
    parameter int DEST_W = 1
);
    logic [DATA_W-1:0]   tdata;
    logic [USER_W-1:0]   tuser;
    logic [ID_W-1:0]     tid;
    logic [DEST_W-1:0]   tdest;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport master (
        output tdata, tuser, tid, tdest, tkeep, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tuser, tid, tdest, tkeep, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/mac_acl_drop_stage_fwd_reg.sv
// One-entry registered AXI-Stream stage carrying payload and all sideband.
// The caller only asserts load when the slot is free or draining this cycle.
module axis_fwd_reg #(
    parameter int DATA_W = 64,
    parameter int USER_W = 51,
    parameter int ID_W   = 4,
    parameter int DEST_W = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [DATA_W-1:0]   in_tdata,
    input  logic [USER_W-1:0]   in_tuser,
    input  logic [ID_W-1:0]     in_tid,
    input  logic [DEST_W-1:0]   in_tdest,
    input  logic [DATA_W/8-1:0] in_tkeep,
    input  logic                in_tlast,
    input  logic                out_tready,
    output logic                out_tvalid,
    output logic [DATA_W-1:0]   out_tdata,
    output logic [USER_W-1:0]   out_tuser,
    output logic [ID_W-1:0]     out_tid,
    output logic [DEST_W-1:0]   out_tdest,
    output logic [DATA_W/8-1:0] out_tkeep,
    output logic                out_tlast
);

    // Valid flag: set on load, cleared when the held beat is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_tvalid <= 1'b0;
        end else if (load) begin
            out_tvalid <= 1'b1;
        end else if (out_tready) begin
            out_tvalid <= 1'b0;
        end
    end

    // Payload only changes on load, so it is stable while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_tdata <= '0;
            out_tuser <= '0;
            out_tid   <= '0;
            out_tdest <= '0;
            out_tkeep <= '0;
            out_tlast <= 1'b0;
        end else if (load) begin
            out_tdata <= in_tdata;
            out_tuser <= in_tuser;
            out_tid   <= in_tid;
            out_tdest <= in_tdest;
            out_tkeep <= in_tkeep;
            out_tlast <= in_tlast;
        end
    end

endmodule

// File: rtl/mac_acl_drop_stage.sv
// ACL drop stage behind the MAC parser: judges each packet once at its first
// beat from the tuser flags/route mask, discards failing packets whole and
// forwards survivors through a one-beat output register.
// Optional build macro: MAC_DROP_CNT_EN adds the saturating drop_count output.
module mac_acl_drop_stage
    import nmu_mac_pkg::*;
#(
    parameter int         AXIS_BUS_WIDTH    = 64,
    parameter int         AXIS_ID_WIDTH     = 4,
    parameter int         AXIS_DEST_WIDTH   = 0,
    parameter int         MAX_PACKET_LENGTH = 1522,
    parameter logic [7:0] DROP_MASK         = 8'h0F,
    parameter bit         DROP_NO_ROUTE     = 1'b1
) (
    input  logic aclk,
    input  logic aresetn,
    mac_acl_drop_stage_if.slave  axis_in,
    mac_acl_drop_stage_if.master axis_out
`ifdef MAC_DROP_CNT_EN
    ,
    output logic [31:0] drop_count
`endif
);

    localparam int NUM_AXIS_ID    = 2 ** AXIS_ID_WIDTH;
    localparam int LEN_W          = $clog2(MAX_PACKET_LENGTH + 1);
    localparam int TU_W           = tu_width(NUM_AXIS_ID, LEN_W);
    localparam int FLG_LO         = tu_flags_lo(NUM_AXIS_ID, LEN_W);
    localparam int ROUTE_LO       = tu_route_lo();
    localparam int EFF_ID_WIDTH   = (AXIS_ID_WIDTH < 1) ? 1 : AXIS_ID_WIDTH;
    localparam int EFF_DEST_WIDTH = (AXIS_DEST_WIDTH < 1) ? 1 : AXIS_DEST_WIDTH;

    acl_state_t             state_q, state_d;
    logic [FLAGS_W-1:0]     flags;
    logic [NUM_AXIS_ID-1:0] route;
    logic                   verdict_drop;
    logic                   in_hs;
    logic                   fwd_load;

    assign flags = axis_in.tuser[FLG_LO +: FLAGS_W];
    assign route = axis_in.tuser[ROUTE_LO +: NUM_AXIS_ID];

    // Verdict is only meaningful at SOP; later beats follow the FSM state
    assign verdict_drop = (|(flags & DROP_MASK)) | (DROP_NO_ROUTE && (route == '0));

    // Discarded beats are always accepted so drops never see backpressure
    assign axis_in.tready = (state_q == DROP)
                          | ((state_q == SOP) & verdict_drop)
                          | ~axis_out.tvalid
                          | axis_out.tready;

    assign in_hs = axis_in.tvalid & axis_in.tready;

    // Packet state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= SOP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and forward decision per accepted beat
    always_comb begin
        state_d  = state_q;
        fwd_load = 1'b0;
        case (state_q)
            SOP: begin
                if (in_hs) begin
                    fwd_load = ~verdict_drop;
                    if (!axis_in.tlast) begin
                        state_d = verdict_drop ? DROP : PASS;
                    end
                end
            end
            PASS: begin
                if (in_hs) begin
                    fwd_load = 1'b1;
                    if (axis_in.tlast) state_d = SOP;
                end
            end
            DROP: begin
                if (in_hs && axis_in.tlast) state_d = SOP;
            end
            default: state_d = SOP;
        endcase
    end

    axis_fwd_reg #(
        .DATA_W (AXIS_BUS_WIDTH),
        .USER_W (TU_W),
        .ID_W   (EFF_ID_WIDTH),
        .DEST_W (EFF_DEST_WIDTH)
    ) u_fwd (
        .clk        (aclk),
        .rst_n      (aresetn),
        .load       (fwd_load),
        .in_tdata   (axis_in.tdata),
        .in_tuser   (axis_in.tuser),
        .in_tid     (axis_in.tid),
        .in_tdest   (axis_in.tdest),
        .in_tkeep   (axis_in.tkeep),
        .in_tlast   (axis_in.tlast),
        .out_tready (axis_out.tready),
        .out_tvalid (axis_out.tvalid),
        .out_tdata  (axis_out.tdata),
        .out_tuser  (axis_out.tuser),
        .out_tid    (axis_out.tid),
        .out_tdest  (axis_out.tdest),
        .out_tkeep  (axis_out.tkeep),
        .out_tlast  (axis_out.tlast)
    );

`ifdef MAC_DROP_CNT_EN
    logic        sop_drop;
    logic [31:0] drop_cnt_q;

    assign sop_drop   = in_hs & (state_q == SOP) & verdict_drop;
    assign drop_count = drop_cnt_q;

    // One count per dropped packet, taken at its SOP beat; saturates
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            drop_cnt_q <= '0;
        end else if (sop_drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_acl_drop_stage.sv
// Directed bench for mac_acl_drop_stage. dut_a uses default parameters;
// dut_b (DROP_NO_ROUTE=0) sees exactly the beats dut_a accepts.
`timescale 1ns/1ps
module tb_mac_acl_drop_stage;

    localparam int TU_W = 51;

    typedef struct {
        logic [63:0]     d;
        logic [TU_W-1:0] u;
        logic            l;
    } beat_t;

    logic  aclk = 1'b0;
    logic  aresetn = 1'b0;
    beat_t q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 aclk = ~aclk;

    mac_acl_drop_stage_if #(.DATA_W(64), .USER_W(TU_W), .ID_W(4), .DEST_W(1)) in_a ();
    mac_acl_drop_stage_if #(.DATA_W(64), .USER_W(TU_W), .ID_W(4), .DEST_W(1)) out_a ();
    mac_acl_drop_stage_if #(.DATA_W(64), .USER_W(TU_W), .ID_W(4), .DEST_W(1)) in_b ();
    mac_acl_drop_stage_if #(.DATA_W(64), .USER_W(TU_W), .ID_W(4), .DEST_W(1)) out_b ();

`ifdef MAC_DROP_CNT_EN
    logic [31:0] drop_count_a, drop_count_b;
`endif

    mac_acl_drop_stage dut_a (
        .aclk(aclk), .aresetn(aresetn), .axis_in(in_a), .axis_out(out_a)
`ifdef MAC_DROP_CNT_EN
        , .drop_count(drop_count_a)
`endif
    );

    mac_acl_drop_stage #(.DROP_NO_ROUTE(1'b0)) dut_b (
        .aclk(aclk), .aresetn(aresetn), .axis_in(in_b), .axis_out(out_b)
`ifdef MAC_DROP_CNT_EN
        , .drop_count(drop_count_b)
`endif
    );

    assign in_b.tdata  = in_a.tdata;
    assign in_b.tuser  = in_a.tuser;
    assign in_b.tid    = in_a.tid;
    assign in_b.tdest  = in_a.tdest;
    assign in_b.tkeep  = in_a.tkeep;
    assign in_b.tlast  = in_a.tlast;
    assign in_b.tvalid = in_a.tvalid & in_a.tready;
    assign out_b.tready = 1'b1;

    // Capture dut_a output beats that will complete at the next edge
    always @(negedge aclk) begin
        if (aresetn && out_a.tvalid && out_a.tready)
            q.push_back('{out_a.tdata, out_a.tuser, out_a.tlast});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [TU_W-1:0] mk_u(input logic [7:0] f, input logic [15:0] r);
        return {f, 16'h88B5, 11'd64, r};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [TU_W-1:0] u, input logic l);
        int n;
        in_a.tdata = d; in_a.tuser = u; in_a.tlast = l;
        in_a.tkeep = 8'hFF; in_a.tid = 4'h3; in_a.tdest = 1'b0;
        in_a.tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge aclk);
            if (in_a.tready) break;
            n++;
            if (n > 50) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: tready=%b after %0d cycles, need 1", in_a.tready, n);
                break;
            end
        end
        @(posedge aclk); #1;
        in_a.tvalid = 1'b0;
    endtask

    task automatic test_reset();
        in_a.tvalid = 1'b0; in_a.tdata = '0; in_a.tuser = '0; in_a.tlast = 1'b0;
        in_a.tkeep = '0; in_a.tid = '0; in_a.tdest = '0;
        out_a.tready = 1'b1;
        aresetn = 1'b0;
        #22;
        n_cmp++; if (out_a.tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b need 0", out_a.tvalid); end
        n_cmp++; if (out_a.tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got %b need 0", out_a.tlast); end
        n_cmp++; if (out_a.tdata !== 64'h0) begin n_err++; $display("FAIL rst_tdata: got %h need 0", out_a.tdata); end
        n_cmp++; if (out_a.tuser !== '0) begin n_err++; $display("FAIL rst_tuser: got %h need 0", out_a.tuser); end
        @(negedge aclk); aresetn = 1'b1;
        @(posedge aclk); #1;
        n_cmp++; if (in_a.tready !== 1'b1) begin n_err++; $display("FAIL rst_tready: got %b need 1", in_a.tready); end
`ifdef MAC_DROP_CNT_EN
        n_cmp++; if (drop_count_a !== 32'd0) begin n_err++; $display("FAIL rst_dropcnt: got %0d need 0", drop_count_a); end
`endif
    endtask

    task automatic test_pass_through();
        logic [63:0]     d;
        logic [TU_W-1:0] u;
        q.delete();
        u = mk_u(8'h00, 16'h0002);
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 3; b++) begin
                d = 64'hA5A5_0000_0000_1000 + 64'(p * 16 + b);
                send_beat(d, u, b == 2);
                n_cmp++; if (out_a.tvalid !== 1'b1) begin n_err++; $display("FAIL pass_lat_vld p%0d b%0d: got %b need 1", p, b, out_a.tvalid); end
                n_cmp++; if (out_a.tdata !== d) begin n_err++; $display("FAIL pass_data p%0d b%0d: got %h need %h", p, b, out_a.tdata, d); end
                n_cmp++; if (out_a.tuser !== u) begin n_err++; $display("FAIL pass_tuser p%0d b%0d: got %h need %h", p, b, out_a.tuser, u); end
                n_cmp++; if (out_a.tlast !== (b == 2)) begin n_err++; $display("FAIL pass_tlast p%0d b%0d: got %b need %b", p, b, out_a.tlast, b == 2); end
            end
        end
        idle(2);
        n_cmp++; if (q.size() !== 9) begin n_err++; $display("FAIL pass_count: got %0d need 9", q.size()); end
        n_cmp++; if (out_a.tvalid !== 1'b0) begin n_err++; $display("FAIL pass_drain: got %b need 0", out_a.tvalid); end
    endtask

    task automatic test_acl_drop();
        q.delete();
        send_beat(64'h2000, mk_u(8'h00, 16'h0002), 1'b0);
        send_beat(64'h2001, mk_u(8'h00, 16'h0002), 1'b1);
        send_beat(64'h2100, mk_u(8'h04, 16'h0002), 1'b0);
        send_beat(64'h2101, mk_u(8'h04, 16'h0002), 1'b0);
        send_beat(64'h2102, mk_u(8'h04, 16'h0002), 1'b1);
        send_beat(64'h2200, mk_u(8'h00, 16'h0002), 1'b0);
        send_beat(64'h2201, mk_u(8'h01, 16'h0002), 1'b1);
        idle(2);
        n_cmp++; if (q.size() !== 4) begin n_err++; $display("FAIL acl_count: got %0d need 4", q.size()); end
        if (q.size() == 4) begin
            n_cmp++; if (q[0].d !== 64'h2000) begin n_err++; $display("FAIL acl_b0: got %h need 2000", q[0].d); end
            n_cmp++; if (q[1].d !== 64'h2001 || q[1].l !== 1'b1) begin n_err++; $display("FAIL acl_b1: got %h/%b need 2001/1", q[1].d, q[1].l); end
            n_cmp++; if (q[2].d !== 64'h2200) begin n_err++; $display("FAIL acl_b2: got %h need 2200", q[2].d); end
            n_cmp++; if (q[3].d !== 64'h2201) begin n_err++; $display("FAIL acl_late_flag: got %h need 2201", q[3].d); end
        end
`ifdef MAC_DROP_CNT_EN
        n_cmp++; if (drop_count_a !== 32'd1) begin n_err++; $display("FAIL acl_dropcnt: got %0d need 1", drop_count_a); end
`endif
    endtask

    task automatic test_no_route();
        q.delete();
        send_beat(64'h3000, mk_u(8'h00, 16'h0000), 1'b0);
        n_cmp++; if (out_b.tvalid !== 1'b1 || out_b.tdata !== 64'h3000) begin n_err++; $display("FAIL noroute_b0: got %b/%h need 1/3000", out_b.tvalid, out_b.tdata); end
        send_beat(64'h3001, mk_u(8'h00, 16'h0000), 1'b1);
        n_cmp++; if (out_b.tdata !== 64'h3001 || out_b.tlast !== 1'b1) begin n_err++; $display("FAIL noroute_b1: got %h/%b need 3001/1", out_b.tdata, out_b.tlast); end
        idle(2);
        n_cmp++; if (q.size() !== 0) begin n_err++; $display("FAIL noroute_drop: got %0d beats need 0", q.size()); end
`ifdef MAC_DROP_CNT_EN
        n_cmp++; if (drop_count_a !== 32'd2) begin n_err++; $display("FAIL noroute_dropcnt: got %0d need 2", drop_count_a); end
        n_cmp++; if (drop_count_b !== 32'd1) begin n_err++; $display("FAIL noroute_dropcnt_b: got %0d need 1", drop_count_b); end
`endif
    endtask

    task automatic test_backpressure_drop();
        q.delete();
        out_a.tready = 1'b0;
        send_beat(64'h4000, mk_u(8'h00, 16'h0002), 1'b1);
        n_cmp++; if (out_a.tvalid !== 1'b1) begin n_err++; $display("FAIL bp_hold_vld: got %b need 1", out_a.tvalid); end
        in_a.tuser = mk_u(8'h00, 16'h0002);
        @(negedge aclk);
        n_cmp++; if (in_a.tready !== 1'b0) begin n_err++; $display("FAIL bp_stall_clean: got %b need 0", in_a.tready); end
        @(posedge aclk); #1;
        for (int b = 0; b < 5; b++) begin
            in_a.tdata = 64'h4100 + 64'(b); in_a.tuser = mk_u(8'h02, 16'h0002);
            in_a.tlast = (b == 4); in_a.tvalid = 1'b1;
            @(negedge aclk);
            n_cmp++; if (in_a.tready !== 1'b1) begin n_err++; $display("FAIL bp_drop_ready b%0d: got %b need 1", b, in_a.tready); end
            @(posedge aclk); #1;
        end
        in_a.tvalid = 1'b0;
        idle(5);
        n_cmp++; if (q.size() !== 0) begin n_err++; $display("FAIL bp_no_out: got %0d beats need 0", q.size()); end
        n_cmp++; if (out_a.tvalid !== 1'b1 || out_a.tdata !== 64'h4000) begin n_err++; $display("FAIL bp_held: got %b/%h need 1/4000", out_a.tvalid, out_a.tdata); end
        out_a.tready = 1'b1;
        idle(2);
        n_cmp++; if (q.size() !== 1) begin n_err++; $display("FAIL bp_release_cnt: got %0d need 1", q.size()); end
        else begin
            n_cmp++; if (q[0].d !== 64'h4000) begin n_err++; $display("FAIL bp_release_data: got %h need 4000", q[0].d); end
        end
        n_cmp++; if (out_a.tvalid !== 1'b0) begin n_err++; $display("FAIL bp_release_vld: got %b need 0", out_a.tvalid); end
`ifdef MAC_DROP_CNT_EN
        n_cmp++; if (drop_count_a !== 32'd3) begin n_err++; $display("FAIL bp_dropcnt: got %0d need 3", drop_count_a); end
`endif
    endtask

    task automatic test_back_to_back();
        q.delete();
        for (int i = 0; i < 6; i++)
            send_beat(64'h5000 + 64'(i), mk_u((i % 2) ? 8'h08 : 8'h00, 16'h0010), 1'b1);
        idle(2);
        n_cmp++; if (q.size() !== 3) begin n_err++; $display("FAIL b2b_count: got %0d need 3", q.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (q[k].d !== 64'h5000 + 64'(2 * k) || q[k].l !== 1'b1 || q[k].u !== mk_u(8'h00, 16'h0010)) begin
                    n_err++;
                    $display("FAIL b2b_beat%0d: got %h/%b/%h need %h/1/%h", k, q[k].d, q[k].l, q[k].u,
                             64'h5000 + 64'(2 * k), mk_u(8'h00, 16'h0010));
                end
            end
        end
`ifdef MAC_DROP_CNT_EN
        n_cmp++; if (drop_count_a !== 32'd6) begin n_err++; $display("FAIL b2b_dropcnt: got %0d need 6", drop_count_a); end
`endif
    endtask

    task automatic test_reset_mid();
        q.delete();
        send_beat(64'h6000, mk_u(8'h00, 16'h0002), 1'b0);
        send_beat(64'h6001, mk_u(8'h00, 16'h0002), 1'b0);
        aresetn = 1'b0;
        #1;
        n_cmp++; if (out_a.tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_vld: got %b need 0", out_a.tvalid); end
        n_cmp++; if (in_a.tready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b need 1", in_a.tready); end
`ifdef MAC_DROP_CNT_EN
        n_cmp++; if (drop_count_a !== 32'd0) begin n_err++; $display("FAIL midrst_dropcnt: got %0d need 0", drop_count_a); end
`endif
        @(negedge aclk); aresetn = 1'b1;
        @(posedge aclk); #1;
        send_beat(64'h6100, mk_u(8'h01, 16'h0002), 1'b1);
        send_beat(64'h6200, mk_u(8'h00, 16'h0002), 1'b0);
        send_beat(64'h6201, mk_u(8'h00, 16'h0002), 1'b1);
        idle(2);
        n_cmp++; if (q.size() !== 3) begin n_err++; $display("FAIL midrst_count: got %0d need 3", q.size()); end
        else begin
            n_cmp++; if (q[0].d !== 64'h6000) begin n_err++; $display("FAIL midrst_pre: got %h need 6000", q[0].d); end
            n_cmp++; if (q[1].d !== 64'h6200 || q[1].l !== 1'b0) begin n_err++; $display("FAIL midrst_new0: got %h/%b need 6200/0", q[1].d, q[1].l); end
            n_cmp++; if (q[2].d !== 64'h6201 || q[2].l !== 1'b1) begin n_err++; $display("FAIL midrst_new1: got %h/%b need 6201/1", q[2].d, q[2].l); end
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_acl_drop();
        test_no_route();
        test_backpressure_drop();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
